// File: rtl/router_fifo_pkg.sv
// Constants and helpers shared by the router register stage, FSM and port FIFOs.
package router_fifo_pkg;

  localparam int ROUTER_WIDTH      = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;
  localparam int HDR_LEN_MSB       = 7;
  localparam int HDR_LEN_LSB       = 2;
  localparam int HDR_ADDR_W        = 2;

  // One extra bit so a length of 63 can hold 64 (payload + parity).
  localparam int PKT_CNT_W = HDR_LEN_MSB - HDR_LEN_LSB + 2;

  function automatic logic [PKT_CNT_W-1:0] hdr_count(
    input logic [ROUTER_WIDTH-1:0] hdr
  );
    return {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]} + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-port output buffer: 16x9 circular store with header tag and
// packet byte counter so the read side knows where a packet ends.
module router_fifo
  import router_fifo_pkg::*;
#(
  parameter int DEPTH = ROUTER_FIFO_DEPTH,
  parameter int WIDTH = ROUTER_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH:0]     mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [PKT_CNT_W-1:0] count;
  logic               wr_go;
  logic               rd_go;
  logic [WIDTH:0]     rd_word;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);

  assign wr_go   = write_enb && !full;
  assign rd_go   = read_enb && !empty;
  assign rd_word = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_go) begin
        mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (rd_go) begin
        rd_ptr   <= rd_ptr + (AW+1)'(1);
        data_out <= rd_word[WIDTH-1:0];
        if (rd_word[WIDTH]) begin
          count <= hdr_count(rd_word[WIDTH-1:0]);
        end else if (count != '0) begin
          count <= count - PKT_CNT_W'(1);
        end
      end else if (count == '0) begin
        // Packet finished: park the output at the idle value.
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: queue model plus directed packets.
module tb_router_fifo;

  logic       clock;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  router_fifo dut (
    .clock      (clock),
    .reset      (reset),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .data_out   (data_out),
    .full       (full),
    .empty      (empty)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  // Model: FIFO as a queue, packet length as a plain integer.
  logic [8:0] q[$];
  int         m_cnt;
  logic [7:0] m_dout;
  logic [8:0] m_w;
  bit         m_rd;
  bit         m_wr;

  always @(posedge clock) begin
    if (reset || soft_reset) begin
      q.delete();
      m_cnt  = 0;
      m_dout = 8'h00;
    end else begin
      m_rd = read_enb && (q.size() != 0);
      m_wr = write_enb && (q.size() != 16);
      if (m_rd) begin
        m_w    = q.pop_front();
        m_dout = m_w[7:0];
        if (m_w[8]) m_cnt = int'(m_w[7:2]) + 1;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
      end else if (m_cnt == 0) begin
        m_dout = 8'h00;
      end
      if (m_wr) q.push_back({lfd_state, data_in});
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      n_cmp++;
      if (data_out !== m_dout) begin
        n_bad++;
        $display("FAIL model data_out: got %h want %h t=%0t",
                 data_out, m_dout, $time);
      end
      n_cmp++;
      if (full !== (q.size() == 16)) begin
        n_bad++;
        $display("FAIL model full: got %b want %b t=%0t",
                 full, q.size() == 16, $time);
      end
      n_cmp++;
      if (empty !== (q.size() == 0)) begin
        n_bad++;
        $display("FAIL model empty: got %b want %b t=%0t",
                 empty, q.size() == 0, $time);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic we, input logic re, input logic lfd,
                      input logic [7:0] din);
    write_enb = we;
    read_enb  = re;
    lfd_state = lfd;
    data_in   = din;
    @(negedge clock);
  endtask

  task automatic idle();
    step(0, 0, 0, 8'h00);
  endtask

  task automatic flush();
    soft_reset = 1;
    idle();
    soft_reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    soft_reset = 0;
    write_enb = 0;
    read_enb = 0;
    lfd_state = 0;
    data_in = 0;

    // Reset for two cycles, with a read attempt that must be ignored.
    @(negedge clock);
    chk_on = 1;
    step(0, 1, 0, 8'h00);
    chk("rst data_out", 32'(data_out), 32'h00);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    reset = 0;
    step(0, 1, 0, 8'h00);
    chk("rd empty ignored", 32'(data_out), 32'h00);

    // Single packet: header 0x0D (len 3) + 3 payload + parity.
    step(1, 0, 1, 8'h0D);
    chk("wr empty falls", 32'(empty), 32'd0);
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    step(1, 0, 0, 8'h33);
    step(1, 0, 0, 8'h3F);
    step(0, 1, 0, 8'h00);
    chk("pkt hdr", 32'(data_out), 32'h0D);
    step(0, 1, 0, 8'h00);
    chk("pkt b1", 32'(data_out), 32'h11);
    step(0, 1, 0, 8'h00);
    chk("pkt b2", 32'(data_out), 32'h22);
    step(0, 1, 0, 8'h00);
    chk("pkt b3", 32'(data_out), 32'h33);
    step(0, 1, 0, 8'h00);
    chk("pkt parity", 32'(data_out), 32'h3F);
    chk("pkt empty", 32'(empty), 32'd1);
    idle();
    chk("pkt end idle", 32'(data_out), 32'h00);

    // Fill past capacity; 17th write is dropped.
    for (int i = 0; i < 17; i++) begin
      step(1, 0, 0, 8'(i));
      if (i == 14) chk("not full at 15", 32'(full), 32'd0);
      if (i == 15) chk("full at 16", 32'(full), 32'd1);
    end
    chk("full after 17", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 8'h00);
      chk("ovf read", 32'(data_out), 32'(i));
      if (i == 0) chk("full drops", 32'(full), 32'd0);
    end
    chk("ovf empty", 32'(empty), 32'd1);
    idle();

    // Simultaneous read/write at full.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'h40 + 8'(i));
    step(1, 1, 0, 8'hAA);
    chk("rw full oldest", 32'(data_out), 32'h40);
    chk("rw full clears", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      step(0, 1, 0, 8'h00);
      chk("rw drain", 32'(data_out), 32'h40 + 32'(i));
    end
    chk("rw dropped", 32'(empty), 32'd1);

    // Simultaneous read/write when empty: only the write happens.
    step(1, 1, 0, 8'h77);
    chk("rw empty wr", 32'(empty), 32'd0);
    step(0, 1, 0, 8'h00);
    chk("rw empty rd", 32'(data_out), 32'h77);

    // Wrap-around with pointers away from zero.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 8'h80 + 8'(i));
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h00);
    chk("wrap10 last", 32'(data_out), 32'h89);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 8'hC0 + 8'(i));
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 8'h00);
      chk("wrap12", 32'(data_out), 32'hC0 + 32'(i));
    end
    chk("wrap empty", 32'(empty), 32'd1);
    idle();

    // Max length header 0xFC: count 64 keeps output held.
    step(1, 0, 1, 8'hFC);
    step(1, 0, 0, 8'h01);
    step(0, 1, 0, 8'h00);
    idle();
    chk("len63 hold", 32'(data_out), 32'hFC);
    step(0, 1, 0, 8'h00);
    idle();
    chk("len63 b1 hold", 32'(data_out), 32'h01);
    flush();

    // Length 0 header: parity only.
    step(1, 0, 1, 8'h01);
    step(1, 0, 0, 8'h55);
    step(0, 1, 0, 8'h00);
    idle();
    chk("len0 hdr hold", 32'(data_out), 32'h01);
    step(0, 1, 0, 8'h00);
    chk("len0 parity", 32'(data_out), 32'h55);
    idle();
    chk("len0 end", 32'(data_out), 32'h00);

    // Soft reset in the middle of a packet.
    step(1, 0, 1, 8'h10);
    step(1, 0, 0, 8'hA1);
    step(1, 0, 0, 8'hA2);
    step(0, 1, 0, 8'h00);
    chk("sr hdr", 32'(data_out), 32'h10);
    flush();
    chk("sr empty", 32'(empty), 32'd1);
    chk("sr data_out", 32'(data_out), 32'h00);
    step(1, 0, 1, 8'h05);
    step(1, 0, 0, 8'hB1);
    step(1, 0, 0, 8'hB2);
    step(0, 1, 0, 8'h00);
    chk("sr new hdr", 32'(data_out), 32'h05);
    step(0, 1, 0, 8'h00);
    chk("sr new b1", 32'(data_out), 32'hB1);
    step(0, 1, 0, 8'h00);
    chk("sr new b2", 32'(data_out), 32'hB2);
    idle();
    chk("sr new end", 32'(data_out), 32'h00);
    idle();

    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end

endmodule
